// File: rtl/stupidrv_pkg.sv
// rtl/stupidrv_pkg.sv - shared types and limits for the stupidrv data-memory arbiter
package stupidrv_pkg;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_CORE = 2'd1,
        OWNER_HOST = 2'd2
    } arb_owner_t;

    // The streak counter is 4 bits wide, so the burst limit must fit below 16.
    localparam int CORE_BURST_MIN = 1;
    localparam int CORE_BURST_MAX = 15;

endpackage

// File: rtl/stupidrv_dmem_arbiter.sv
// rtl/stupidrv_dmem_arbiter.sv - core/host arbiter for one single-port data memory
module stupidrv_dmem_arbiter
    import stupidrv_pkg::*;
#(
    parameter int CORE_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_dmem_valid,
    input  logic [31:0] core_dmem_addr,
    input  logic [3:0]  core_dmem_wstrb,
    input  logic [31:0] core_dmem_wdata,
    output logic [31:0] core_dmem_rdata,
    output logic        stall,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_addr,
    input  logic [3:0]  host_wstrb,
    input  logic [31:0] host_wdata,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (CORE_BURST < CORE_BURST_MIN || CORE_BURST > CORE_BURST_MAX) begin : g_bad_burst
        $error("CORE_BURST out of range");
    end

    localparam logic [3:0] BURST = 4'(CORE_BURST);

    logic [3:0]  streak_q, streak_d;
    arb_owner_t  rd_owner_q, rd_owner_d;
    logic [31:0] core_hold_q;
    logic        gnt_core, gnt_host;

    always_comb begin
        gnt_core   = 1'b0;
        gnt_host   = 1'b0;
        stall      = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'd0;
        mem_wstrb  = 4'd0;
        mem_wdata  = 32'd0;
        streak_d   = streak_q;
        rd_owner_d = OWNER_IDLE;

        // Reset masks every grant so nothing reaches the memory or the core.
        if (!reset) begin
            gnt_core = core_dmem_valid && !(host_valid && streak_q == BURST);
            gnt_host = host_valid && !gnt_core;
            stall    = core_dmem_valid && !gnt_core;
        end

        if (gnt_core) begin
            mem_valid = 1'b1;
            mem_addr  = core_dmem_addr;
            mem_wstrb = core_dmem_wstrb;
            mem_wdata = core_dmem_wdata;
            if (core_dmem_wstrb == 4'd0) rd_owner_d = OWNER_CORE;
        end else if (gnt_host) begin
            mem_valid = 1'b1;
            mem_addr  = host_addr;
            mem_wstrb = host_wstrb;
            mem_wdata = host_wdata;
            if (host_wstrb == 4'd0) rd_owner_d = OWNER_HOST;
        end

        if (!host_valid || gnt_host) begin
            streak_d = 4'd0;
        end else if (gnt_core && streak_q != BURST) begin
            streak_d = streak_q + 4'd1;
        end
    end

    assign host_ready      = gnt_host;
    assign core_dmem_rdata = (rd_owner_q == OWNER_CORE) ? mem_rdata : core_hold_q;
    assign host_rvalid     = (rd_owner_q == OWNER_HOST) && !reset;
    assign host_rdata      = host_rvalid ? mem_rdata : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            streak_q    <= 4'd0;
            rd_owner_q  <= OWNER_IDLE;
            core_hold_q <= 32'd0;
        end else begin
            streak_q   <= streak_d;
            rd_owner_q <= rd_owner_d;
            // Keeps returned data visible to a core that is stalled in its return cycle.
            if (rd_owner_q == OWNER_CORE) core_hold_q <= mem_rdata;
        end
    end

endmodule

// File: doc/stupidrv_dmem_arbiter.md
# stupidrv_dmem_arbiter

Shares one synchronous single-port data memory between the stupidrv core's data port and one external host master (loader, debug or DMA). Each cycle it picks exactly one requester and drives the memory with that request. When the core loses, it freezes the core through `stall`. It returns read data to the winner one cycle later. Core requests have priority, but a burst limit bounds host starvation.

## Interface
Parameters:
- `CORE_BURST`, default 4: maximum number of consecutive contested grants the core can win before the host gets one slot; legal range 1..15.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `core_dmem_valid` in 1: core request.
- `core_dmem_addr` in 32: core address, word-aligned.
- `core_dmem_wstrb` in 4: core write strobes; 0 means read.
- `core_dmem_wdata` in 32: core write data.
- `core_dmem_rdata` out 32: core read data.
- `stall` out 1: freezes the core.
- `host_valid` in 1: host request.
- `host_ready` out 1: host request accepted this cycle.
- `host_addr` in 32, `host_wstrb` in 4, `host_wdata` in 32: host request fields.
- `host_rvalid` out 1: host read data valid.
- `host_rdata` out 32: host read data.
- `mem_valid` out 1, `mem_addr` out 32, `mem_wstrb` out 4, `mem_wdata` out 32: memory request.
- `mem_rdata` in 32: memory read data, one cycle after the request.

## Operation
- Arbitration is combinational, once per cycle.
  - `gnt_core = core_dmem_valid && !(host_valid && streak == CORE_BURST)`.
  - `gnt_host = host_valid && !gnt_core`.
- `stall = core_dmem_valid && !gnt_core`. `stall` is never asserted when the core makes no request.
- `host_ready = gnt_host`. The host holds `host_valid` and its fields stable until `host_ready`.
- Memory mux:
  - `mem_valid = gnt_core || gnt_host`.
  - Address, strobes and data come from the granted port.
  - When `mem_valid` is 0, `mem_wstrb` = 0 and `mem_addr`/`mem_wdata` = 0.
- `streak` is a 4-bit counter:
  - increments on a cycle with both requesting and core granted;
  - clears when the host is granted or `host_valid` is 0;
  - saturates at `CORE_BURST`.
- `rd_owner_q` is a 2-bit state: IDLE / CORE / HOST. It records which port issued a read (granted, wstrb == 0) in the previous cycle. Writes set it to IDLE.
- Core read return:
  - `core_dmem_rdata = (rd_owner_q == CORE) ? mem_rdata : core_hold_q`.
  - `core_hold_q` loads `mem_rdata` whenever `rd_owner_q == CORE`.
  - The core therefore sees correct data even if it is stalled in the return cycle.
- Host read return:
  - `host_rvalid = (rd_owner_q == HOST)`;
  - `host_rdata = mem_rdata`, or 0 when `host_rvalid` is 0.
- Writes produce no response on either port.
- The core re-asserts its read during its writeback cycle. This is arbitrated as a normal request; no special case.

## Timing
- Grant, `stall`, `host_ready` and `mem_*` are combinational in the request cycle t.
- Read data arrives at t+1. There is no additional latency.
- Throughput is one memory access per cycle.
- Simultaneous requests:
  - core wins while `streak < CORE_BURST`;
  - the host wins exactly one cycle, then `streak` = 0.
- Host-only traffic is never throttled.
- During `reset` high:
  - `mem_valid`, `stall`, `host_ready` and `host_rvalid` are 0;
  - the cycle after reset, `rd_owner_q` = IDLE, `streak` = 0, `core_hold_q` = 0.
- Reset asserted at t+1 after an accepted host read: `host_rvalid` is suppressed, and the read is lost.
- Counter wrap is impossible because `streak` saturates at `CORE_BURST`.

## Structure
- Package `stupidrv_pkg` holds:
  - the owner enum `arb_owner_t` (IDLE=0, CORE=1, HOST=2);
  - the `CORE_BURST` range check constant.
- Single module. No sub-module is warranted; the fairness counter is a few lines.
- All registers sit in one clocked process with a synchronous reset branch. Grant and mux logic form one combinational process.

## Test plan
- Core-only read: core reads addr 0x10, memory holds 0xDEADBEEF -> `stall` = 0; `core_dmem_rdata` = 0xDEADBEEF at t+1, and still 0xDEADBEEF at t+2 with `mem_rdata` changed.
- Host-only write then read: write 0x12345678 with wstrb 1111 to 0x20, then read 0x20 -> `host_ready` both cycles; `host_rvalid` only the cycle after the read, with data 0x12345678.
- Contention, `CORE_BURST` = 2, both requesting continuously:
  - grant sequence C,C,H,C,C,H;
  - `stall` high exactly on the H cycles;
  - `streak` returns to 0 after each H.
- Core stalled in its return cycle: core read granted at t, host wins at t+1 -> core data stays valid through `core_hold_q` at t+2.
- Reset at t+1 after a host read at t -> `host_rvalid` = 0 at t+1 and t+2; `mem_valid` = 0 while reset is high.
- Idle: no requests -> `mem_valid` = 0, `mem_wstrb` = 0, `stall` = 0, `host_rvalid` = 0.
